demux_1to4_wb: RTL and testbench

//  Writeback-side counterpart of the 16-bit 4-to-1 select path.

---
 rtl/demux_1to4_wb_pkg.sv | 26 ++
 rtl/demux_1to4_wb_if.sv | 26 ++
 rtl/demux_1to4_wb_hold_slot.sv | 49 ++++
 rtl/demux_1to4_wb.sv | 85 ++++++++
 tb/tb_demux_1to4_wb.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/demux_1to4_wb_pkg.sv
// Shared constants and helpers for the 1-to-4 writeback demux.
// Channel indices, select width and the select-to-one-hot decode.
package demux_1to4_wb_pkg;

   localparam int SEL_W     = 2;
   localparam int NUM_CH    = 4;
   localparam int CH_A      = 0;
   localparam int CH_B      = 1;
   localparam int CH_C      = 2;
   localparam int CH_D      = 3;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_CNT_W = 8;

   function automatic logic [NUM_CH-1:0] sel_decode(input logic [SEL_W-1:0] sel);
      logic [NUM_CH-1:0] oh;
      case (sel)
         2'b00:   oh = 4'b0001;
         2'b01:   oh = 4'b0010;
         2'b10:   oh = 4'b0100;
         2'b11:   oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/demux_1to4_wb_if.sv
// Input handshake plus the four output channel handshakes of the writeback demux.
interface demux_1to4_wb_if #(parameter int WIDTH = 16);
   import demux_1to4_wb_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [SEL_W-1:0]    in_sel;
   logic [WIDTH-1:0]    in_data;
   logic [NUM_CH-1:0]   out_valid;
   logic [NUM_CH-1:0]   out_ready;
   logic [WIDTH-1:0]    out_a;
   logic [WIDTH-1:0]    out_b;
   logic [WIDTH-1:0]    out_c;
   logic [WIDTH-1:0]    out_d;

   modport slave (
      input  in_valid, in_sel, in_data, out_ready,
      output in_ready, out_valid, out_a, out_b, out_c, out_d
   );

   modport master (
      output in_valid, in_sel, in_data, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_c, out_d
   );

endinterface

// File: rtl/demux_1to4_wb_hold_slot.sv
// One-entry holding register for a single writeback channel.
// Flush beats load beats drain; data only changes on a load.
module wb_hold_slot #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             load_i,
   input  logic             drain_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   // Next-state for the valid flag and the held datum.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (drain_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Slot state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/demux_1to4_wb.sv
// Steers one input datum into one of four registered writeback channels.
// Holds the select decode, input ready logic and the accepted-transfer counter.
module demux_1to4_wb
   import demux_1to4_wb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              flush,
   demux_1to4_wb_if.slave    bus,
   output logic [CNT_W-1:0]  accept_cnt
);

   logic [NUM_CH-1:0] sel_oh_s;
   logic [NUM_CH-1:0] load_s;
   logic [NUM_CH-1:0] drain_s;
   logic [NUM_CH-1:0] hold_valid_s;
   logic [WIDTH-1:0]  hold_data_s [NUM_CH];
   logic              in_ready_s;
   logic              accept_s;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Ready, accept and per-channel load/drain strobes.
   always_comb begin
      sel_oh_s   = sel_decode(bus.in_sel);
      in_ready_s = 1'b0;
      if (rst) begin
         in_ready_s = 1'b0;
      end else begin
         // A FULL slot can take a new datum only if it drains on the same edge.
         in_ready_s = enable & ~flush &
                      (~hold_valid_s[bus.in_sel] | bus.out_ready[bus.in_sel]);
      end
      accept_s = bus.in_valid & in_ready_s;
      if (accept_s) begin
         load_s = sel_oh_s;
      end else begin
         load_s = '0;
      end
      drain_s = hold_valid_s & bus.out_ready;
   end

   // Accepted-transfer counter next state, wraps naturally.
   always_comb begin
      if (accept_s) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Accepted-transfer counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
      wb_hold_slot #(.WIDTH(WIDTH)) u_slot (
         .clk     (clk),
         .rst     (rst),
         .flush_i (flush),
         .load_i  (load_s[g]),
         .drain_i (drain_s[g]),
         .data_i  (bus.in_data),
         .valid_o (hold_valid_s[g]),
         .data_o  (hold_data_s[g])
      );
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = hold_valid_s;
   assign bus.out_a     = hold_data_s[CH_A];
   assign bus.out_b     = hold_data_s[CH_B];
   assign bus.out_c     = hold_data_s[CH_C];
   assign bus.out_d     = hold_data_s[CH_D];
   assign accept_cnt    = cnt_q;

endmodule

// File: tb/tb_demux_1to4_wb.sv
// Bench for demux_1to4_wb: directed vector table, reset/wrap sequences and random traffic.
module tb_demux_1to4_wb;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] accept_cnt;

   demux_1to4_wb_if #(.WIDTH(16)) ifc ();

   demux_1to4_wb #(.WIDTH(16), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .flush      (flush),
      .bus        (ifc.slave),
      .accept_cnt (accept_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: per-channel occupancy and contents, plus transfer count.
   logic        m_v [4];
   logic [15:0] m_d [4];
   int          m_cnt;

   typedef struct {
      logic        en;
      logic        fl;
      logic        iv;
      logic [1:0]  sel;
      logic [15:0] data;
      logic [3:0]  ordy;
      logic        exp_rdy;
      logic [3:0]  exp_ov;
      logic [7:0]  exp_cnt;
      int          exp_ch;
      logic [15:0] exp_dat;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] get_ch(input int i);
      case (i)
         0:       return ifc.out_a;
         1:       return ifc.out_b;
         2:       return ifc.out_c;
         default: return ifc.out_d;
      endcase
   endfunction

   function automatic logic model_ready();
      int s = int'(ifc.in_sel);
      return enable && !flush && (!m_v[s] || ifc.out_ready[s]);
   endfunction

   function automatic logic [3:0] model_ov();
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = m_v[i];
      return r;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_v[i] = 1'b0;
         m_d[i] = 16'h0000;
      end
      m_cnt = 0;
   endtask

   // Apply one clock edge's worth of behaviour to the model using the held inputs.
   task automatic model_edge();
      logic acc;
      int   s;
      acc = ifc.in_valid && model_ready();
      s   = int'(ifc.in_sel);
      for (int i = 0; i < 4; i++) begin
         if (flush)                  m_v[i] = 1'b0;
         else if (acc && s == i)     begin m_v[i] = 1'b1; m_d[i] = ifc.in_data; end
         else if (ifc.out_ready[i])  m_v[i] = 1'b0;
      end
      if (acc) m_cnt = (m_cnt + 1) % 256;
   endtask

   task automatic drive(input logic en, input logic fl, input logic iv,
                        input logic [1:0] sel, input logic [15:0] data, input logic [3:0] ordy);
      enable        = en;
      flush         = fl;
      ifc.in_valid  = iv;
      ifc.in_sel    = sel;
      ifc.in_data   = data;
      ifc.out_ready = ordy;
   endtask

   // One cycle fully checked against the model; inputs must already be driven.
   task automatic cycle_model(input string tag);
      #1;
      check({tag, ".in_ready"}, 32'(ifc.in_ready), 32'(model_ready()));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check({tag, ".out_valid"}, 32'(ifc.out_valid), 32'(model_ov()));
      check({tag, ".accept_cnt"}, 32'(accept_cnt), 32'(m_cnt));
      for (int i = 0; i < 4; i++)
         if (m_v[i]) check({tag, ".data"}, 32'(get_ch(i)), 32'(m_d[i]));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 4'b0000);
      model_clear();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      ifc.in_valid  = 1'b0;
      ifc.in_sel    = 2'b00;
      ifc.in_data   = 16'h0000;
      ifc.out_ready = 4'b0000;
      model_clear();

      // Reset state.
      @(negedge clk);
      check("rst.out_valid", 32'(ifc.out_valid), 32'h0);
      check("rst.cnt", 32'(accept_cnt), 32'h0);
      check("rst.in_ready", 32'(ifc.in_ready), 32'h0);
      do_reset();

      // Directed vectors: {en, fl, iv, sel, data, ordy, rdy, ov_after, cnt_after, ch, dat}
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'd2, 16'hBEEF, 4'b0000, 1'b1, 4'b0100, 8'd1, 2, 16'hBEEF};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 2'd2, 16'h1234, 4'b0000, 1'b0, 4'b0100, 8'd1, 2, 16'hBEEF};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 2'd1, 16'h0001, 4'b0010, 1'b1, 4'b0110, 8'd2, 1, 16'h0001};
      vecs[3]  = '{1'b1, 1'b0, 1'b1, 2'd1, 16'h0002, 4'b0010, 1'b1, 4'b0110, 8'd3, 1, 16'h0002};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 2'd1, 16'h0003, 4'b0010, 1'b1, 4'b0110, 8'd4, 1, 16'h0003};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 4'b0110, 1'b1, 4'b0000, 8'd4, 1, 16'h0003};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 2'd0, 16'h1111, 4'b0000, 1'b1, 4'b0001, 8'd5, 0, 16'h1111};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 2'd3, 16'h2222, 4'b0000, 1'b1, 4'b1001, 8'd6, 3, 16'h2222};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 4'b1001, 1'b1, 4'b0000, 8'd6, 3, 16'h2222};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 2'd1, 16'h0AAA, 4'b0000, 1'b1, 4'b0010, 8'd7, 1, 16'h0AAA};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 2'd0, 16'h5555, 4'b0010, 1'b0, 4'b0000, 8'd7, 0, 16'h1111};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 2'd1, 16'h0BBB, 4'b0000, 1'b1, 4'b0010, 8'd8, 1, 16'h0BBB};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 2'd0, 16'h6666, 4'b0000, 1'b0, 4'b0000, 8'd8, 1, 16'h0BBB};

      for (int k = 0; k < 13; k++) begin
         drive(vecs[k].en, vecs[k].fl, vecs[k].iv, vecs[k].sel, vecs[k].data, vecs[k].ordy);
         #1;
         check($sformatf("vec%0d.in_ready", k), 32'(ifc.in_ready), 32'(vecs[k].exp_rdy));
         @(posedge clk);
         model_edge();
         @(negedge clk);
         check($sformatf("vec%0d.out_valid", k), 32'(ifc.out_valid), 32'(vecs[k].exp_ov));
         check($sformatf("vec%0d.cnt", k), 32'(accept_cnt), 32'(vecs[k].exp_cnt));
         check($sformatf("vec%0d.data", k), 32'(get_ch(vecs[k].exp_ch)), 32'(vecs[k].exp_dat));
      end

      // Reset mid-transfer clears everything before any clock edge.
      drive(1'b1, 1'b0, 1'b1, 2'd3, 16'hC0DE, 4'b0000);
      cycle_model("preload");
      drive(1'b1, 1'b0, 1'b1, 2'd0, 16'h7777, 4'b0000);
      #1;
      rst = 1'b1;
      #1;
      check("midrst.out_valid", 32'(ifc.out_valid), 32'h0);
      check("midrst.out_a", 32'(ifc.out_a), 32'h0);
      check("midrst.out_b", 32'(ifc.out_b), 32'h0);
      check("midrst.out_c", 32'(ifc.out_c), 32'h0);
      check("midrst.out_d", 32'(ifc.out_d), 32'h0);
      check("midrst.cnt", 32'(accept_cnt), 32'h0);
      check("midrst.in_ready", 32'(ifc.in_ready), 32'h0);
      do_reset();

      // Counter wrap: 256 streamed accepts into channel a.
      for (int k = 1; k <= 256; k++) begin
         drive(1'b1, 1'b0, 1'b1, 2'd0, 16'(k), 4'b0001);
         cycle_model("wrap");
         if (k == 255) check("wrap.cnt_ff", 32'(accept_cnt), 32'hFF);
      end
      check("wrap.cnt_00", 32'(accept_cnt), 32'h00);

      // Random traffic against the model.
      do_reset();
      for (int k = 0; k < 400; k++) begin
         drive($urandom_range(0, 7) != 0, $urandom_range(0, 24) == 0,
               $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
               16'($urandom), 4'($urandom));
         cycle_model("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
